// File: rtl/retire_arbiter_pkg.sv
// Shared definitions for the retire arbiter: default sizes, the per-requester
// result record, the arbiter state enum and the requester index map.
package retire_arbiter_pkg;

  localparam int N_REQ        = 4;
  localparam int TAG_W        = 4;
  localparam int FLUSH_CYCLES = 2;

  // Requester index map
  localparam int REQ_ALU = 0;
  localparam int REQ_MUL = 1;
  localparam int REQ_BR  = 2;
  localparam int REQ_LSU = 3;

  // One execution-unit result as seen by the retire unit.
  // result[0] = write/store data, result[1] = jump target/store address.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [1:0][31:0] result;
    logic             we;
    logic             jump;
    logic             write;
    logic [1:0]       size;
  } retire_req_t;

  typedef enum logic {RUN, FLUSH} arb_state_t;

endpackage

// File: rtl/retire_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Ports: mask (eligible requesters), ptr (highest-priority index),
//        grant_oh (one-hot winner), grant_idx (binary winner), any (a winner exists).
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  int j;

  // Scan N positions starting at ptr, wrapping; first set mask bit wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && mask[j]) begin
        any         = 1'b1;
        grant_oh[j] = 1'b1;
        grant_idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/retire_arbiter.sv
// retire_arbiter: shares the single retire path among execution units.
// Drops stale results (tag != mirrored retire tag), grants one candidate per
// cycle round-robin, registers it onto the retire bus, and blocks grants for
// FLUSH_CYCLES after each granted taken jump.
// Ports:
//   clk, reset            clock, async active-high reset
//   req_valid/req_ready   per-requester handshake (ready = granted or dropped)
//   req_tag/result/we/jump/write/size  per-requester result fields
//   result, we, jump, write_in, size_in, instruction_tag  registered retire bus
//   ret_valid, grant_id   bus carries a grant / index of granted requester
//   curr_tag              mirrored retire tag
module retire_arbiter
  import retire_arbiter_pkg::*;
#(
  parameter int N_REQ        = retire_arbiter_pkg::N_REQ,
  parameter int TAG_W        = retire_arbiter_pkg::TAG_W,
  parameter int FLUSH_CYCLES = retire_arbiter_pkg::FLUSH_CYCLES,
  localparam int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_REQ-1:0]                req_valid,
  output logic [N_REQ-1:0]                req_ready,
  input  logic [N_REQ-1:0][TAG_W-1:0]     req_tag,
  input  logic [N_REQ-1:0][1:0][31:0]     req_result,
  input  logic [N_REQ-1:0]                req_we,
  input  logic [N_REQ-1:0]                req_jump,
  input  logic [N_REQ-1:0]                req_write,
  input  logic [N_REQ-1:0][1:0]           req_size,
  output logic [1:0][31:0]                result,
  output logic                            we,
  output logic                            jump,
  output logic                            write_in,
  output logic [1:0]                      size_in,
  output logic [TAG_W-1:0]                instruction_tag,
  output logic                            ret_valid,
  output logic [IDX_W-1:0]                grant_id,
  output logic [TAG_W-1:0]                curr_tag
);

  arb_state_t       state, state_nx;
  logic [2:0]       cnt, cnt_nx;
  logic [IDX_W-1:0] rr_ptr;

  logic [N_REQ-1:0] stale, cand, mask, grant_oh;
  logic [IDX_W-1:0] gidx;
  logic             any;
  retire_req_t      sel;

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      stale[i] = req_valid[i] && (req_tag[i] != curr_tag);
  end

  assign cand = req_valid & ~stale;
  assign mask = (state == RUN) ? cand : '0;

  rr_picker #(.N(N_REQ), .IDX_W(IDX_W)) u_pick (
    .mask      (mask),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (gidx),
    .any       (any)
  );

  // Stale drops and the grant are both acknowledged in the same cycle.
  assign req_ready = reset ? '0 : (stale | grant_oh);

  always_comb begin
    sel.tag    = req_tag[gidx];
    sel.result = req_result[gidx];
    sel.we     = req_we[gidx];
    sel.jump   = req_jump[gidx];
    sel.write  = req_write[gidx];
    sel.size   = req_size[gidx];
  end

  // Flush FSM: cnt counts remaining grant-free cycles minus one.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      RUN: if (any && sel.jump) begin
        state_nx = FLUSH;
        cnt_nx   = 3'(FLUSH_CYCLES - 1);
      end
      FLUSH: if (cnt == '0) state_nx = RUN;
             else           cnt_nx   = cnt - 3'd1;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr          <= '0;
      curr_tag        <= '0;
      result          <= '0;
      we              <= 1'b0;
      jump            <= 1'b0;
      write_in        <= 1'b0;
      size_in         <= '0;
      instruction_tag <= '0;
      ret_valid       <= 1'b0;
      grant_id        <= '0;
    end else if (any) begin
      rr_ptr          <= (gidx == IDX_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      if (sel.jump) curr_tag <= curr_tag + 1'b1;
      result          <= sel.result;
      we              <= sel.we;
      jump            <= sel.jump;
      write_in        <= sel.write;
      size_in         <= sel.size;
      instruction_tag <= sel.tag;
      ret_valid       <= 1'b1;
      grant_id        <= gidx;
    end else begin
      result          <= '0;
      we              <= 1'b0;
      jump            <= 1'b0;
      write_in        <= 1'b0;
      size_in         <= '0;
      instruction_tag <= curr_tag;
      ret_valid       <= 1'b0;
      grant_id        <= '0;
    end
  end

endmodule

// File: doc/retire_arbiter.md
# retire_arbiter

Shares the single retire path between the execution units. Each cycle it selects at most one valid, non-stale result by round-robin and presents it, registered, on the retire unit's input bus. It keeps a mirror of the retire tag so results from a mispredicted path are dropped before they consume a retire slot. It holds grants for a fixed flush window after every taken jump.

## Interface
- N_REQ, 4, number of requesters (0 ALU, 1 MUL, 2 BRANCH, 3 LSU)
- TAG_W, 4, instruction tag width; must match the retire unit
- FLUSH_CYCLES, 2, grant-free cycles after a granted taken jump (1..7)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  requester holds a result
- req_ready  out  N_REQ  result accepted (granted or dropped) this cycle
- req_tag  in  N_REQ x TAG_W  tag of each result
- req_result  in  N_REQ x 2 x 32  [0] write data / store data, [1] jump target / store address
- req_we, req_jump, req_write  in  N_REQ each  register write, taken jump, memory store
- req_size  in  N_REQ x 2  store size
- result  out  2 x 32  to retire unit
- we, jump, write_in  out  1 each  to retire unit
- size_in  out  2  to retire unit
- instruction_tag  out  TAG_W  to retire unit
- ret_valid  out  1  bus carries a granted result
- grant_id  out  log2(N_REQ)  index of the granted requester (valid with ret_valid)
- curr_tag  out  TAG_W  mirrored retire tag

## Operation
- Stale means req_valid=1 and req_tag != curr_tag. All stale requesters get req_ready=1 in the same cycle and are discarded, in any state. No retire slot is used.
- Candidate means valid and not stale. In RUN, the first candidate at or after rr_ptr (modulo N_REQ) is granted: req_ready=1 for that index only.
- After a grant, rr_ptr becomes grant index + 1, wrapping N_REQ-1 to 0. With no grant, rr_ptr holds.
- Tag advance: a granted request with req_jump=1 increments curr_tag by 1 at the next edge (wraps 15 to 0). The state goes to FLUSH with cnt = FLUSH_CYCLES-1.
- FLUSH: no grants, stale drops continue. cnt decrements each cycle, and the state returns to RUN when cnt=0 on the clock edge.
- Output bus, registered:
  - On a grant, the granted fields plus instruction_tag = req_tag, ret_valid=1.
  - Otherwise result=0, we=0, jump=0, write_in=0, size_in=0, instruction_tag=curr_tag, ret_valid=0, grant_id=0.
- Requester handshake: the request stays stable while req_valid=1 and req_ready=0. It is released in the cycle req_ready=1.

## Timing
- Grant decision is combinational from req_valid/req_tag/rr_ptr/state. The granted result appears on the output bus one cycle later (latency 1).
- curr_tag updates on the same edge that registers the jump onto the bus. A request with the old tag is stale from the following cycle on.
- A jump granted at cycle t puts the arbiter in FLUSH for cycles t+1..t+FLUSH_CYCLES. The next grant is possible at t+FLUSH_CYCLES+1.
- Throughput is 1 grant/cycle in RUN. A continuously valid requester waits at most N_REQ-1 grants.
- Simultaneous stale and candidate requests: drops and the grant happen in the same cycle.
- Reset (any time, including during FLUSH):
  - State RUN, cnt=0, rr_ptr=0, curr_tag=0, req_ready=0.
  - Every output goes to 0, ret_valid=0.
  - In-flight grants are lost.

## Structure
- Shared package adds:
  - N_REQ, TAG_W, FLUSH_CYCLES defaults.
  - retire_req_t: tag, result[2], we, jump, write, size.
  - arb_state_t enum {RUN, FLUSH}.
  - Requester index constants REQ_ALU, REQ_MUL, REQ_BR, REQ_LSU.
- One sub-module: rr_picker, a combinational round-robin one-hot selector taking a mask and a pointer and returning grant_oh, grant_idx, and any.
- State, counter, pointer and output registers live in retire_arbiter.

## Test plan
- Round-robin: all 4 valid, tag 0, we=1, results 0x10..0x13 → grant_id 0,1,2,3 on consecutive cycles, WrData order 0x10..0x13, ret_valid 1 each cycle.
- Taken jump: BRANCH granted with jump=1, result[1]=0x200, while ALU is valid, tag 0 → jump=1, result[1]=0x200 next cycle; curr_tag=1; ALU req_ready=1 (dropped) and no grant for 2 cycles.
- Flush window: FLUSH_CYCLES=2, MUL valid with tag 1 during FLUSH → granted exactly 3 cycles after the branch grant.
- Tag wrap: curr_tag=15, granted jump → curr_tag=0; a request with tag 0 is then granted and one with tag 15 is dropped.
- Store pass-through: LSU write=1, size=2, result[0]=0xCAFE, result[1]=0x1000 → next cycle write_in=1, size_in=2, result[0]=0xCAFE, result[1]=0x1000, we=0.
- Reset in FLUSH: assert reset at cycle 1 of FLUSH → outputs 0 immediately, curr_tag=0, rr_ptr=0. After release, a tag-0 request from index 0 is granted on the first cycle.
